// File: rtl/f_npc.sv
// f_npc: fetch-stage next-PC unit.
// Selects the next fetch PC from exception vector, register jump, immediate
// jump, taken branch or sequential increment, tracks a deferred exception
// while the pipeline is stalled, and counts resolved and taken branches.
// Optional feature: define BRANCH_LIKELY_EN to enable delay-slot nullify
// for not-taken likely branches; otherwise nullify is tied low.
module f_npc (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        d_valid,
    input  logic [31:0] d_pc,
    input  logic [2:0]  br_type,
    input  logic [1:0]  acmpb,
    input  logic [1:0]  acmp0,
    input  logic [15:0] imm16,
    input  logic        jmp_imm,
    input  logic [25:0] jmp_idx,
    input  logic        jmp_reg,
    input  logic [31:0] rs_val,
    input  logic        exc_req,
    input  logic        br_likely,
    output logic [31:0] f_pc,
    output logic        redirect,
    output logic        exc_pend,
    output logic        nullify,
    output logic [31:0] br_cnt,
    output logic [31:0] taken_cnt
);

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLEZ = 3'b011;
    localparam logic [2:0] BR_BGTZ = 3'b100;
    localparam logic [2:0] BR_BLTZ = 3'b101;
    localparam logic [2:0] BR_BGEZ = 3'b110;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;

    typedef enum logic {
        RUN      = 1'b0,
        EXC_PEND = 1'b1
    } state_t;

    state_t      state;

    logic        update;
    logic        exc_take;
    logic        is_branch;
    logic        br_taken;
    logic [31:0] pc_plus4;
    logic [31:0] dpc_plus4;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] jimm_target;
    logic [31:0] jreg_target;
    logic [31:0] next_pc;
    logic        next_nonseq;
    logic        count_br;
    logic        count_taken;
    logic        unused_bits;

    assign update = !stall;

    // A queued exception always wins the first free cycle; otherwise a fresh request does.
    assign exc_take = update && ((state == EXC_PEND) || exc_req);

    assign is_branch = d_valid && (br_type != 3'b000) && (br_type != 3'b111);

    // Branch condition decode; compare code 11 never matches any accepted set.
    always_comb begin
        br_taken = 1'b0;
        case (br_type)
            BR_BEQ:  br_taken = (acmpb == CMP_EQ);
            BR_BNE:  br_taken = (acmpb == CMP_GT) || (acmpb == CMP_LT);
            BR_BLEZ: br_taken = (acmp0 == CMP_EQ) || (acmp0 == CMP_LT);
            BR_BGTZ: br_taken = (acmp0 == CMP_GT);
            BR_BLTZ: br_taken = (acmp0 == CMP_LT);
            BR_BGEZ: br_taken = (acmp0 == CMP_EQ) || (acmp0 == CMP_GT);
            default: br_taken = 1'b0;
        endcase
    end

    assign pc_plus4    = f_pc + 32'd4;
    assign dpc_plus4   = d_pc + 32'd4;
    assign br_offset   = {{14{imm16[15]}}, imm16, 2'b00};
    assign br_target   = dpc_plus4 + br_offset;
    assign jimm_target = {dpc_plus4[31:28], jmp_idx, 2'b00};
    assign jreg_target = {rs_val[31:2], 2'b00};

    assign unused_bits = ^rs_val[1:0];

    // Next-PC priority mux: exception, register jump, immediate jump, taken branch, sequential.
    always_comb begin
        next_pc     = pc_plus4;
        next_nonseq = 1'b0;
        if (exc_take) begin
            next_pc     = EXC_VEC;
            next_nonseq = 1'b1;
        end else if (d_valid && jmp_reg) begin
            next_pc     = jreg_target;
            next_nonseq = 1'b1;
        end else if (d_valid && jmp_imm) begin
            next_pc     = jimm_target;
            next_nonseq = 1'b1;
        end else if (is_branch && br_taken) begin
            next_pc     = br_target;
            next_nonseq = 1'b1;
        end
    end

    assign count_br    = update && !exc_take && is_branch;
    assign count_taken = count_br && br_taken;

    // Fetch PC register plus the one-cycle redirect pulse following any non-sequential load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_pc     <= RESET_PC;
            redirect <= 1'b0;
        end else begin
            redirect <= update && next_nonseq;
            if (update) begin
                f_pc <= next_pc;
            end
        end
    end

    // Saturating resolved-branch and taken-branch counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_cnt    <= 32'd0;
            taken_cnt <= 32'd0;
        end else begin
            if (count_br && (br_cnt != CNT_MAX)) begin
                br_cnt <= br_cnt + 32'd1;
            end
            if (count_taken && (taken_cnt != CNT_MAX)) begin
                taken_cnt <= taken_cnt + 32'd1;
            end
        end
    end

    // Exception FSM: park a request that arrives during a stall until the pipeline frees up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            exc_pend <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (exc_req && stall) begin
                        state    <= EXC_PEND;
                        exc_pend <= 1'b1;
                    end
                end
                EXC_PEND: begin
                    if (!stall) begin
                        state    <= RUN;
                        exc_pend <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    exc_pend <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_LIKELY_EN
    // Kill the delay slot for one cycle after a not-taken likely branch resolves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nullify <= 1'b0;
        end else begin
            nullify <= update && !exc_take && is_branch && !br_taken && br_likely;
        end
    end
`else
    logic unused_likely;

    assign unused_likely = br_likely;
    assign nullify       = 1'b0;
`endif

endmodule

// File: tb/tb_f_npc.sv
// tb_f_npc: scoreboard bench for the f_npc next-PC unit.
// Build with BRANCH_LIKELY_EN defined to also exercise delay-slot nullify.
module tb_f_npc;

`ifdef BRANCH_LIKELY_EN
    localparam logic LIKELY = 1'b1;
`else
    localparam logic LIKELY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        d_valid;
    logic [31:0] d_pc;
    logic [2:0]  br_type;
    logic [1:0]  acmpb;
    logic [1:0]  acmp0;
    logic [15:0] imm16;
    logic        jmp_imm;
    logic [25:0] jmp_idx;
    logic        jmp_reg;
    logic [31:0] rs_val;
    logic        exc_req;
    logic        br_likely;
    logic [31:0] f_pc;
    logic        redirect;
    logic        exc_pend;
    logic        nullify;
    logic [31:0] br_cnt;
    logic [31:0] taken_cnt;

    typedef struct {
        logic [31:0] pc;
        logic        redir;
        logic        pend;
        logic        nul;
        logic [31:0] bc;
        logic [31:0] tc;
    } exp_t;

    exp_t        sbq[$];

    int          errCount   = 0;
    int          checkCount = 0;

    logic [31:0] mPc;
    logic        mRedir;
    logic        mPend;
    logic        mNul;
    logic [31:0] mBc;
    logic [31:0] mTc;

    f_npc dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .d_valid   (d_valid),
        .d_pc      (d_pc),
        .br_type   (br_type),
        .acmpb     (acmpb),
        .acmp0     (acmp0),
        .imm16     (imm16),
        .jmp_imm   (jmp_imm),
        .jmp_idx   (jmp_idx),
        .jmp_reg   (jmp_reg),
        .rs_val    (rs_val),
        .exc_req   (exc_req),
        .br_likely (br_likely),
        .f_pc      (f_pc),
        .redirect  (redirect),
        .exc_pend  (exc_pend),
        .nullify   (nullify),
        .br_cnt    (br_cnt),
        .taken_cnt (taken_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic modelTaken(input logic [2:0] t, input logic [1:0] ab, input logic [1:0] a0);
        case (t)
            3'd1:    return ab inside {2'b00};
            3'd2:    return ab inside {2'b01, 2'b10};
            3'd3:    return a0 inside {2'b00, 2'b10};
            3'd4:    return a0 inside {2'b01};
            3'd5:    return a0 inside {2'b10};
            3'd6:    return a0 inside {2'b00, 2'b01};
            default: return 1'b0;
        endcase
    endfunction

    task automatic clearInputs;
        stall     = 1'b0;
        d_valid   = 1'b0;
        d_pc      = 32'd0;
        br_type   = 3'd0;
        acmpb     = 2'd0;
        acmp0     = 2'd0;
        imm16     = 16'd0;
        jmp_imm   = 1'b0;
        jmp_idx   = 26'd0;
        jmp_reg   = 1'b0;
        rs_val    = 32'd0;
        exc_req   = 1'b0;
        br_likely = 1'b0;
    endtask

    task automatic modelReset;
        mPc    = 32'h0000_3000;
        mRedir = 1'b0;
        mPend  = 1'b0;
        mNul   = 1'b0;
        mBc    = 32'd0;
        mTc    = 32'd0;
        sbq.delete();
    endtask

    // Advance the reference model by one clock using the inputs now driven, and queue the result.
    task automatic modelStep;
        exp_t        e;
        logic        isBr;
        logic        tk;
        logic [31:0] pc4;
        isBr = d_valid && (br_type inside {[3'd1:3'd6]});
        tk   = isBr && modelTaken(br_type, acmpb, acmp0);
        pc4  = d_pc + 32'd4;
        if (stall) begin
            if (!mPend && exc_req) mPend = 1'b1;
            mRedir = 1'b0;
            mNul   = 1'b0;
        end else if (mPend || exc_req) begin
            mPc    = 32'h0000_4180;
            mRedir = 1'b1;
            mNul   = 1'b0;
            mPend  = 1'b0;
        end else begin
            mRedir = 1'b1;
            if (d_valid && jmp_reg)      mPc = {rs_val[31:2], 2'b00};
            else if (d_valid && jmp_imm) mPc = {pc4[31:28], jmp_idx, 2'b00};
            else if (tk)                 mPc = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
            else begin
                mPc    = mPc + 32'd4;
                mRedir = 1'b0;
            end
            if (isBr && (mBc != 32'hFFFF_FFFF)) mBc = mBc + 32'd1;
            if (tk && (mTc != 32'hFFFF_FFFF))   mTc = mTc + 32'd1;
            mNul = LIKELY && isBr && !tk && br_likely;
        end
        e.pc    = mPc;
        e.redir = mRedir;
        e.pend  = mPend;
        e.nul   = mNul;
        e.bc    = mBc;
        e.tc    = mTc;
        sbq.push_back(e);
    endtask

    task automatic checkScoreboard;
        exp_t e;
        if (sbq.size() == 0) begin
            checkOutput("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            checkOutput("f_pc", f_pc, e.pc);
            checkOutput("redirect", 32'(redirect), 32'(e.redir));
            checkOutput("exc_pend", 32'(exc_pend), 32'(e.pend));
            checkOutput("nullify", 32'(nullify), 32'(e.nul));
            checkOutput("br_cnt", br_cnt, e.bc);
            checkOutput("taken_cnt", taken_cnt, e.tc);
        end
    endtask

    // Drive one cycle: inputs are already set; model, clock, then compare just after the edge.
    task automatic applyStimulus;
        modelStep();
        @(posedge clk);
        #1;
        checkScoreboard();
    endtask

    task automatic setBranch(input logic [31:0] pc, input logic [2:0] t, input logic [1:0] ab,
                             input logic [1:0] a0, input logic [15:0] imm);
        clearInputs();
        d_valid = 1'b1;
        d_pc    = pc;
        br_type = t;
        acmpb   = ab;
        acmp0   = a0;
        imm16   = imm;
    endtask

    initial begin
        clearInputs();
        reset = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pc", f_pc, 32'h0000_3000);
        checkOutput("rst_redir", 32'(redirect), 32'd0);
        checkOutput("rst_pend", 32'(exc_pend), 32'd0);
        checkOutput("rst_nul", 32'(nullify), 32'd0);
        checkOutput("rst_bc", br_cnt, 32'd0);
        checkOutput("rst_tc", taken_cnt, 32'd0);
        reset = 1'b0;

        // Sequential fetch after reset release
        applyStimulus();
        checkOutput("seq_pc1", f_pc, 32'h0000_3004);
        applyStimulus();
        checkOutput("seq_pc2", f_pc, 32'h0000_3008);
        checkOutput("seq_redir", 32'(redirect), 32'd0);

        // Taken beq with negative offset
        setBranch(32'h0000_3010, 3'b001, 2'b00, 2'b00, 16'hFFFC);
        applyStimulus();
        checkOutput("beq_pc", f_pc, 32'h0000_3004);
        checkOutput("beq_redir", 32'(redirect), 32'd1);
        checkOutput("beq_bc", br_cnt, 32'd1);
        checkOutput("beq_tc", taken_cnt, 32'd1);
        clearInputs();
        applyStimulus();
        checkOutput("beq_redir_drop", 32'(redirect), 32'd0);

        // Invalid compare code: not taken, counted, optional nullify
        setBranch(32'h0000_3010, 3'b001, 2'b11, 2'b00, 16'hFFFC);
        br_likely = 1'b1;
        applyStimulus();
        checkOutput("inv_pc", f_pc, 32'h0000_300C);
        checkOutput("inv_tc", taken_cnt, 32'd1);
        checkOutput("inv_nul", 32'(nullify), 32'(LIKELY));
        clearInputs();
        applyStimulus();
        checkOutput("inv_nul_drop", 32'(nullify), 32'd0);

        // Every branch type against every compare code, plus a d_valid=0 pass
        for (int t = 0; t < 8; t++) begin
            for (int c = 0; c < 4; c++) begin
                setBranch(32'h0000_5000 + 32'(t * 64), 3'(t), 2'(c), 2'(3 - c), 16'(c * 8 + 1));
                br_likely = c[0];
                applyStimulus();
            end
        end
        setBranch(32'h0000_6000, 3'b001, 2'b00, 2'b00, 16'h0010);
        d_valid = 1'b0;
        jmp_reg = 1'b1;
        applyStimulus();

        // Branch held by stall must not count
        setBranch(32'h0000_6000, 3'b001, 2'b00, 2'b00, 16'h0010);
        stall = 1'b1;
        applyStimulus();

        // Exception while stalled is deferred, further requests ignored
        clearInputs();
        stall   = 1'b1;
        exc_req = 1'b1;
        repeat (3) applyStimulus();
        checkOutput("pend_set", 32'(exc_pend), 32'd1);
        clearInputs();
        stall = 1'b1;
        applyStimulus();
        clearInputs();
        applyStimulus();
        checkOutput("pend_pc", f_pc, 32'h0000_4180);
        checkOutput("pend_clr", 32'(exc_pend), 32'd0);
        checkOutput("pend_redir", 32'(redirect), 32'd1);
        applyStimulus();
        checkOutput("pend_after", f_pc, 32'h0000_4184);

        // Register jump beats immediate jump
        clearInputs();
        d_valid = 1'b1;
        jmp_reg = 1'b1;
        jmp_imm = 1'b1;
        rs_val  = 32'h1234_5677;
        jmp_idx = 26'h3FF_FFFF;
        applyStimulus();
        checkOutput("jr_pc", f_pc, 32'h1234_5674);

        // Exception beats jumps and branches and freezes counters
        setBranch(32'h0000_7000, 3'b001, 2'b00, 2'b00, 16'h0004);
        jmp_reg = 1'b1;
        rs_val  = 32'h1234_5677;
        exc_req = 1'b1;
        applyStimulus();
        checkOutput("exc_pc", f_pc, 32'h0000_4180);

        // Immediate jump keeps the upper nibble of d_pc+4
        clearInputs();
        d_valid = 1'b1;
        jmp_imm = 1'b1;
        d_pc    = 32'hAFFF_FFFC;
        jmp_idx = 26'h000_0123;
        applyStimulus();
        checkOutput("j_pc", f_pc, 32'hB000_048C);

        // Sequential wrap at the top of the address space
        clearInputs();
        d_valid = 1'b1;
        jmp_reg = 1'b1;
        rs_val  = 32'hFFFF_FFFF;
        applyStimulus();
        clearInputs();
        applyStimulus();
        checkOutput("wrap_pc", f_pc, 32'h0000_0000);

        // Counter saturation
        force dut.br_cnt = 32'hFFFF_FFFE;
        force dut.taken_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.br_cnt;
        release dut.taken_cnt;
        mBc = 32'hFFFF_FFFE;
        mTc = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            setBranch(32'h0000_0100, 3'b110, 2'b00, 2'b01, 16'h0002);
            applyStimulus();
        end
        checkOutput("sat_bc", br_cnt, 32'hFFFF_FFFF);
        checkOutput("sat_tc", taken_cnt, 32'hFFFF_FFFF);

        // Constrained-random traffic
        for (int i = 0; i < 80; i++) begin
            stall     = ($urandom_range(0, 4) == 0);
            d_valid   = ($urandom_range(0, 3) != 0);
            d_pc      = $urandom;
            br_type   = 3'($urandom);
            acmpb     = 2'($urandom);
            acmp0     = 2'($urandom);
            imm16     = 16'($urandom);
            jmp_imm   = ($urandom_range(0, 5) == 0);
            jmp_idx   = 26'($urandom);
            jmp_reg   = ($urandom_range(0, 5) == 0);
            rs_val    = $urandom;
            exc_req   = ($urandom_range(0, 9) == 0);
            br_likely = 1'($urandom);
            applyStimulus();
        end

        // Mid-cycle reset discards a pending exception
        clearInputs();
        stall   = 1'b1;
        exc_req = 1'b1;
        applyStimulus();
        checkOutput("mid_pend_set", 32'(exc_pend), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_pc", f_pc, 32'h0000_3000);
        checkOutput("mid_pend", 32'(exc_pend), 32'd0);
        checkOutput("mid_bc", br_cnt, 32'd0);
        checkOutput("mid_tc", taken_cnt, 32'd0);
        modelReset();
        clearInputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus();
        checkOutput("post_rst_pc", f_pc, 32'h0000_3004);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
